// File: rtl/horda_controle.sv
// Enemy formation controller: shared origin, alive mask, step timer and march sequencing.
// One step per periodo+2 clocks; kills are taken with valid/ready only while the timer is counting.
module horda_controle #(
    parameter int COLS       = 8,
    parameter int ROWS       = 4,
    parameter int IDXW       = 5,
    parameter int CELL_W     = 40,
    parameter int CELL_H     = 32,
    parameter int ENEMY_W    = 30,
    parameter int ENEMY_H    = 30,
    parameter int STEP_X     = 20,
    parameter int STEP_Y     = 20,
    parameter int X0         = 40,
    parameter int Y0         = 40,
    parameter int SCREEN_W   = 640,
    parameter int FLOOR_Y    = 400,
    parameter int PERIOD_MAX = 25_000_000,
    parameter int PERIOD_MIN = 2_500_000,
    parameter int PERIOD_DEC = 700_000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 pausa,
    input  logic                 reiniciarJogo,
    input  logic                 kill_valid,
    input  logic [IDXW-1:0]      kill_idx,
    output logic                 kill_ready,
    output logic [9:0]           origem_x,
    output logic [9:0]           origem_y,
    output logic [ROWS*COLS-1:0] vivos,
    output logic                 sentido,
    output logic                 passo,
    output logic                 vitoria,
    output logic                 invasao
);
    localparam int N   = ROWS * COLS;
    localparam int CW  = $clog2(PERIOD_MAX + 1);
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RLW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] P_MAX = CW'(PERIOD_MAX);
    localparam logic [CW-1:0] P_MIN = CW'(PERIOD_MIN);
    localparam logic [CW-1:0] P_DEC = CW'(PERIOD_DEC);
    localparam int unsigned   P_TH  = PERIOD_MIN + PERIOD_DEC;

    typedef enum logic [1:0] {CONTANDO, AVALIA, MOVE, FIM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, periodo_q, periodo_d;
    logic [9:0]      ox_q, ox_d, oy_q, oy_d;
    logic [N-1:0]    vivos_q, vivos_d;
    logic            sentido_q, sentido_d, vitoria_q, vitoria_d, invasao_q, invasao_d;
    logic [10:0]     left_q, left_d, right_q, right_d;
    logic [RLW-1:0]  rowmax_q, rowmax_d;

    logic [COLS-1:0] col_alive;
    logic [ROWS-1:0] row_alive;
    logic [CLW-1:0]  col_min, col_max;
    logic [N-1:0]    kill_mask;
    logic            kill_hit, descend;
    logic [9:0]      oy_step;
    logic [10:0]     bottom;

    // Extent of the surviving formation, latched in AVALIA for the MOVE decision.
    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (vivos_q[r*COLS+c]) begin
                    col_alive[c] = 1'b1;
                    row_alive[r] = 1'b1;
                end
        col_min  = '0;
        col_max  = '0;
        rowmax_d = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_alive[c]) col_min = CLW'(c);
        for (int c = 0; c < COLS; c++)      if (col_alive[c]) col_max = CLW'(c);
        for (int r = 0; r < ROWS; r++)      if (row_alive[r]) rowmax_d = RLW'(r);
        left_d  = {1'b0, ox_q} + 11'(col_min) * 11'(CELL_W);
        right_d = {1'b0, ox_q} + 11'(col_max) * 11'(CELL_W) + 11'(ENEMY_W);
    end

    always_comb begin
        kill_mask = N'(1) << kill_idx;
        kill_hit  = (32'(kill_idx) < N) && ((vivos_q & kill_mask) != '0);
        descend   = sentido_q ? (right_q + 11'(STEP_X) > 11'(SCREEN_W))
                              : (left_q < 11'(STEP_X));
        oy_step   = descend ? oy_q + 10'(STEP_Y) : oy_q;
        bottom    = {1'b0, oy_step} + 11'(rowmax_q) * 11'(CELL_H) + 11'(ENEMY_H);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= CONTANDO;
            cnt_q     <= '0;
            periodo_q <= P_MAX;
            ox_q      <= 10'(X0);
            oy_q      <= 10'(Y0);
            vivos_q   <= '1;
            sentido_q <= 1'b1;
            vitoria_q <= 1'b0;
            invasao_q <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            rowmax_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            periodo_q <= periodo_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            vivos_q   <= vivos_d;
            sentido_q <= sentido_d;
            vitoria_q <= vitoria_d;
            invasao_q <= invasao_d;
            if (state_q == AVALIA) begin
                left_q   <= left_d;
                right_q  <= right_d;
                rowmax_q <= rowmax_d;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        periodo_d = periodo_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        vivos_d   = vivos_q;
        sentido_d = sentido_q;
        vitoria_d = vitoria_q;
        invasao_d = invasao_q;
        case (state_q)
            CONTANDO: begin
                if (!pausa) begin
                    // >= so a period shortened below the running count still terminates
                    if (cnt_q >= periodo_q - CW'(1)) begin
                        cnt_d   = '0;
                        state_d = AVALIA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (kill_valid && kill_ready && kill_hit) begin
                    vivos_d   = vivos_q & ~kill_mask;
                    periodo_d = (32'(periodo_q) >= P_TH) ? periodo_q - P_DEC : P_MIN;
                    if (vivos_d == '0) begin
                        state_d   = FIM;
                        vitoria_d = 1'b1;
                    end
                end
            end
            AVALIA: state_d = MOVE;
            MOVE: begin
                oy_d = oy_step;
                if (descend) sentido_d = ~sentido_q;
                else         ox_d = sentido_q ? ox_q + 10'(STEP_X) : ox_q - 10'(STEP_X);
                if (bottom >= 11'(FLOOR_Y)) begin
                    state_d   = FIM;
                    invasao_d = 1'b1;
                end else begin
                    state_d = CONTANDO;
                end
            end
            FIM: ;
        endcase
        if (reiniciarJogo) begin
            state_d   = CONTANDO;
            cnt_d     = '0;
            periodo_d = P_MAX;
            ox_d      = 10'(X0);
            oy_d      = 10'(Y0);
            vivos_d   = '1;
            sentido_d = 1'b1;
            vitoria_d = 1'b0;
            invasao_d = 1'b0;
        end
    end

    always_comb begin
        kill_ready = (state_q == CONTANDO) && reset;
        passo      = (state_q == MOVE);
    end

    assign origem_x = ox_q;
    assign origem_y = oy_q;
    assign vivos    = vivos_q;
    assign sentido  = sentido_q;
    assign vitoria  = vitoria_q;
    assign invasao  = invasao_q;

endmodule

// File: tb/tb_horda_controle.sv
// Directed bench for horda_controle with a shortened step period; dut_b starts low on screen to reach invasion.
module tb_horda_controle;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, pausa_a, rein_a, kv_a, kr_a, sent_a, passo_a, vit_a, inv_a;
    logic [5:0]  ki_a;
    logic [9:0]  ox_a, oy_a;
    logic [31:0] viv_a;
    logic        rst_b, pausa_b, rein_b, kv_b, kr_b, sent_b, passo_b, vit_b, inv_b;
    logic [5:0]  ki_b;
    logic [9:0]  ox_b, oy_b;
    logic [31:0] viv_b;

    horda_controle #(.IDXW(6), .PERIOD_MAX(10), .PERIOD_MIN(4), .PERIOD_DEC(3)) dut_a (
        .CLOCK_50(clk), .reset(rst_a), .pausa(pausa_a), .reiniciarJogo(rein_a),
        .kill_valid(kv_a), .kill_idx(ki_a), .kill_ready(kr_a),
        .origem_x(ox_a), .origem_y(oy_a), .vivos(viv_a), .sentido(sent_a),
        .passo(passo_a), .vitoria(vit_a), .invasao(inv_a));

    horda_controle #(.IDXW(6), .Y0(260), .PERIOD_MAX(10), .PERIOD_MIN(4), .PERIOD_DEC(3)) dut_b (
        .CLOCK_50(clk), .reset(rst_b), .pausa(pausa_b), .reiniciarJogo(rein_b),
        .kill_valid(kv_b), .kill_idx(ki_b), .kill_ready(kr_b),
        .origem_x(ox_b), .origem_y(oy_b), .vivos(viv_b), .sentido(sent_b),
        .passo(passo_b), .vitoria(vit_b), .invasao(inv_b));

    typedef struct { int step; logic [9:0] ox; logic [9:0] oy; logic sent; } march_t;
    typedef struct { logic [5:0] idx; logic [31:0] vivos; } kill_t;

    int     cmps = 0;
    int     errs = 0;
    int     cyc  = 0;
    march_t mt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_passo(input bit b, output int at);
        int n;
        n  = 0;
        at = -1;
        while (at < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if ((b ? passo_b : passo_a) === 1'b1) at = cyc;
        end
        if (at < 0) begin
            cmps++;
            errs++;
            $display("FAIL passo_timeout dut%0d: no passo within %0d clocks, want one", b, n);
        end
    endtask

    task automatic run_march(input bit b, input int nsteps, input int gap,
                             output int first_at, output int last_at);
        int at, prev;
        prev = -1; first_at = -1; last_at = -1;
        for (int s = 1; s <= nsteps; s++) begin
            wait_passo(b, at);
            if (s == 1) first_at = at;
            else check($sformatf("gap_d%0d_s%0d", b, s), at - prev, gap);
            prev    = at;
            last_at = at;
            @(negedge clk);
            foreach (mt[k]) if (mt[k].step == s) begin
                check($sformatf("ox_d%0d_s%0d", b, s), b ? ox_b : ox_a, mt[k].ox);
                check($sformatf("oy_d%0d_s%0d", b, s), b ? oy_b : oy_a, mt[k].oy);
                check($sformatf("sent_d%0d_s%0d", b, s), b ? sent_b : sent_a, mt[k].sent);
            end
        end
    endtask

    task automatic do_kill(input logic [5:0] idx, input string nm);
        int n;
        n = 0;
        while (kr_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, kr_a, 1);
        kv_a = 1'b1;
        ki_a = idx;
        @(negedge clk);
        kv_a = 1'b0;
    endtask

    task automatic restart_a();
        rein_a = 1'b1;
        @(negedge clk);
        rein_a = 1'b0;
    endtask

    initial begin
        kill_t kt[7];
        int f, l, at, t0, bad, pulses;
        logic [9:0] fx, fy;

        rst_a = 0; pausa_a = 0; rein_a = 0; kv_a = 0; ki_a = '0;
        rst_b = 0; pausa_b = 0; rein_b = 0; kv_b = 0; ki_b = '0;
        repeat (3) @(negedge clk);

        check("rst_ox", ox_a, 40);
        check("rst_oy", oy_a, 40);
        check("rst_vivos", viv_a, 32'hFFFF_FFFF);
        check("rst_sent", sent_a, 1);
        check("rst_passo", passo_a, 0);
        check("rst_vit", vit_a, 0);
        check("rst_inv", inv_a, 0);
        check("rst_ready", kr_a, 0);

        // Plain march: 14 right steps, descent on the 15th, then left.
        rst_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("ready_after_rst", kr_a, 1);
        mt.delete();
        mt.push_back('{1,  10'd60,  10'd40, 1'b1});
        mt.push_back('{14, 10'd320, 10'd40, 1'b1});
        mt.push_back('{15, 10'd320, 10'd60, 1'b0});
        mt.push_back('{16, 10'd300, 10'd60, 1'b0});
        run_march(0, 16, 12, f, l);
        check("first_step_latency", f - t0, 11);

        // Repeat kill and out-of-range kill are consumed without effect.
        restart_a();
        check("rein_ox", ox_a, 40);
        check("rein_oy", oy_a, 40);
        check("rein_sent", sent_a, 1);
        check("rein_vivos", viv_a, 32'hFFFF_FFFF);
        kt[0] = '{6'd3,  32'hFFFF_FFF7};
        kt[1] = '{6'd3,  32'hFFFF_FFF7};
        kt[2] = '{6'd32, 32'hFFFF_FFF7};
        for (int i = 0; i < 3; i++) begin
            do_kill(kt[i].idx, $sformatf("kill_rep%0d", i));
            check($sformatf("vivos_rep%0d", i), viv_a, kt[i].vivos);
        end
        mt.delete();
        run_march(0, 2, 9, f, l);

        // Rightmost column wiped out: period clamps at 4 and the march runs two steps further.
        restart_a();
        kt[3] = '{6'd7,  32'hFFFF_FF7F};
        kt[4] = '{6'd15, 32'hFFFF_7F7F};
        kt[5] = '{6'd23, 32'hFF7F_7F7F};
        kt[6] = '{6'd31, 32'h7F7F_7F7F};
        for (int i = 3; i < 7; i++) begin
            do_kill(kt[i].idx, $sformatf("kill_col%0d", i));
            check($sformatf("vivos_col%0d", i), viv_a, kt[i].vivos);
        end
        mt.push_back('{16, 10'd360, 10'd40, 1'b1});
        mt.push_back('{17, 10'd360, 10'd60, 1'b0});
        run_march(0, 17, 6, f, l);

        // 50-clock pause right after a step, with a kill in the middle of it.
        pausa_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                check("pause_kill_ready", kr_a, 1);
                kv_a = 1'b1;
                ki_a = 6'd0;
            end
            if (i == 11) begin
                kv_a = 1'b0;
                check("pause_kill_vivos", viv_a, 32'h7F7F_7F7E);
            end
            @(negedge clk);
        end
        pausa_a = 1'b0;
        wait_passo(0, at);
        check("pause_gap", at - l, 56);

        // Kill the whole wave.
        restart_a();
        for (int i = 0; i < 32; i++) begin
            do_kill(6'(i), $sformatf("kill_all%0d", i));
            if (i == 30) check("vit_before_last", vit_a, 0);
        end
        check("vit_after_last", vit_a, 1);
        check("vivos_empty", viv_a, 0);
        check("win_ready", kr_a, 0);
        pulses = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (passo_a !== 1'b0) pulses++;
            if (kr_a !== 1'b0 || vit_a !== 1'b1) bad++;
        end
        check("win_no_passo", pulses, 0);
        check("win_frozen", bad, 0);

        // Asynchronous reset while MOVE is active.
        restart_a();
        mt.delete();
        mt.push_back('{3, 10'd100, 10'd40, 1'b1});
        run_march(0, 3, 12, f, l);
        wait_passo(0, at);
        check("move_passo_seen", passo_a, 1);
        rst_a = 1'b0;
        #1;
        check("arst_passo", passo_a, 0);
        check("arst_ox", ox_a, 40);
        check("arst_oy", oy_a, 40);
        check("arst_sent", sent_a, 1);
        check("arst_ready", kr_a, 0);
        check("arst_vit", vit_a, 0);
        @(negedge clk);
        rst_a = 1'b1;

        // Low start: the first descent reaches the floor line.
        rst_b = 1'b1;
        mt.delete();
        mt.push_back('{14, 10'd320, 10'd260, 1'b1});
        mt.push_back('{15, 10'd320, 10'd280, 1'b0});
        run_march(1, 15, 12, f, l);
        check("inv_flag", inv_b, 1);
        check("inv_vit", vit_b, 0);
        check("inv_ready", kr_b, 0);
        fx = ox_b;
        fy = oy_b;
        kv_b = 1'b1;
        ki_b = 6'd0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (kr_b !== 1'b0 || passo_b !== 1'b0 || ox_b !== fx || oy_b !== fy || inv_b !== 1'b1) bad++;
        end
        kv_b = 1'b0;
        check("inv_frozen", bad, 0);
        check("inv_vivos_kept", viv_b, 32'hFFFF_FFFF);
        rein_b = 1'b1;
        @(negedge clk);
        rein_b = 1'b0;
        check("inv_rein_ox", ox_b, 40);
        check("inv_rein_oy", oy_b, 260);
        check("inv_rein_sent", sent_b, 1);
        check("inv_rein_inv", inv_b, 0);
        check("inv_rein_vivos", viv_b, 32'hFFFF_FFFF);
        check("inv_rein_ready", kr_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
